bootstrap_loader: RTL and testbench
===================================

BOOTSTRAP_LOADER -- requirements
Module: bootstrap_loader

Interface
REQ-001 SHALL have parameter LENGTH, default 64, meaning the number of bytes to write into microcode SRAM; legal range 1..4096.
REQ-002 SHALL have parameter STROBE_CYCLES, default 1, meaning the width of the BOOTSTRAP_N_WE low pulse in CLK cycles; legal range 1..15.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on rising edge.
REQ-004 SHALL have port N_RST, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port IN_VALID, input, 1 bit: the byte source presents IN_DATA.
REQ-006 SHALL have port IN_DATA, input, 8 bits: microcode byte from the byte source.
REQ-007 SHALL have port IN_READY, output, 1 bit: the loader accepts a byte this cycle.
REQ-008 SHALL have port BOOTSTRAP_ADDR, output, 12 bits: microcode SRAM write address.
REQ-009 SHALL have port BOOTSTRAP_DATA, output, 8 bits: microcode SRAM write data.
REQ-010 SHALL have port BOOTSTRAP_N_WE, output, 1 bit: active-low SRAM write strobe.
REQ-011 SHALL have port N_BOOTED, output, 1 bit: low once loading is complete; it enables SRAM output to control logic.

Function
REQ-012 SHALL implement states LOAD, SETUP, STROBE, HOLD, DONE.
REQ-013 SHALL drive IN_READY high iff state=LOAD and N_RST high.
REQ-014 SHALL take a byte only on a rising edge with IN_VALID=1 and IN_READY=1; it SHALL capture IN_DATA into BOOTSTRAP_DATA and go LOAD->SETUP.
REQ-015 SHALL stay in LOAD with all outputs unchanged while IN_VALID=0; it SHALL ignore IN_VALID in every state other than LOAD.
REQ-016 SHALL go SETUP->STROBE after exactly 1 cycle, with BOOTSTRAP_N_WE=1 in SETUP (address/data setup).
REQ-017 SHALL hold BOOTSTRAP_N_WE=0 in STROBE for exactly STROBE_CYCLES cycles, using a 4-bit down-counter, then go to HOLD.
REQ-018 SHALL drive BOOTSTRAP_N_WE=1 in HOLD for 1 cycle with ADDR/DATA unchanged (hold time), then:
 - if BOOTSTRAP_ADDR = LENGTH-1: go to DONE, with ADDR unchanged;
 - otherwise: increment BOOTSTRAP_ADDR by 1 and go to LOAD.
REQ-019 SHALL keep BOOTSTRAP_ADDR and BOOTSTRAP_DATA stable from SETUP entry through HOLD exit; they SHALL never change while BOOTSTRAP_N_WE=0.
REQ-020 SHALL register BOOTSTRAP_N_WE; it SHALL be glitch-free and low only in STROBE.
REQ-021 SHALL detect the last byte by the ADDR=LENGTH-1 compare, not by 12-bit wrap; ADDR SHALL never exceed LENGTH-1, including LENGTH=4096.
REQ-022 SHALL fix the minimum per-byte latency at accept edge to next IN_READY at STROBE_CYCLES+3 cycles.
REQ-023 SHALL, in DONE: drive N_BOOTED=0, BOOTSTRAP_N_WE=1, IN_READY=0; DONE is terminal until reset.
REQ-024 SHALL drive N_BOOTED=1 in every state except DONE; N_BOOTED and BOOTSTRAP_N_WE SHALL never both be 0.
REQ-025 SHALL, with LENGTH=1, go to DONE after the first HOLD.

Reset
REQ-026 SHALL, while N_RST=0, force state=LOAD, BOOTSTRAP_ADDR=0, BOOTSTRAP_DATA=0, BOOTSTRAP_N_WE=1, N_BOOTED=1, IN_READY=0, strobe counter=0.
REQ-027 SHALL, when reset is asserted mid-operation (including during STROBE), release BOOTSTRAP_N_WE high immediately (asynchronous) and restart loading from address 0 after release.
REQ-028 SHALL assert IN_READY in the first cycle after N_RST deasserts.

Verification
REQ-029 Bench SHALL cover: LENGTH=4, STROBE_CYCLES=1, bytes 0xA1,0xB2,0xC3,0xD4 with IN_VALID held high -> writes to addrs 0..3 each 4 cycles apart, one N_WE low cycle each, N_BOOTED=0 after the 4th HOLD.
REQ-030 Bench SHALL cover: random IN_VALID gaps of 0-5 cycles, LENGTH=16 -> SRAM contents match the stream exactly; no extra or missed writes (16 N_WE falling edges).
REQ-031 Bench SHALL cover: STROBE_CYCLES=3 -> N_WE low exactly 3 cycles per byte; ADDR/DATA stable from SETUP to HOLD.
REQ-032 Bench SHALL cover: N_RST pulsed low during STROBE of byte 2 -> N_WE goes high asynchronously; reload writes from addr 0; N_BOOTED stays 1 until the full reload completes.
REQ-033 Bench SHALL cover: LENGTH=4096 -> last write at addr 0xFFF, then DONE; ADDR never wraps to 0; IN_VALID held high in DONE produces no further writes.
REQ-034 Bench SHALL cover: LENGTH=1 -> a single write at addr 0, then N_BOOTED=0; asserted invariant N_BOOTED|BOOTSTRAP_N_WE=1 on every cycle.

Source files
------------

// File: rtl/bootstrap_loader.sv
// Copies a byte stream into microcode SRAM one write cycle per byte, then
// releases N_BOOTED so the SRAM contents can drive the control logic.
module bootstrap_loader #(
  parameter int LENGTH        = 64,
  parameter int STROBE_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        N_RST,
  input  logic        IN_VALID,
  input  logic [7:0]  IN_DATA,
  output logic        IN_READY,
  output logic [11:0] BOOTSTRAP_ADDR,
  output logic [7:0]  BOOTSTRAP_DATA,
  output logic        BOOTSTRAP_N_WE,
  output logic        N_BOOTED
);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Last byte is found by compare so LENGTH=4096 never wraps the address.
  localparam logic [11:0] LAST_ADDR   = 12'(LENGTH - 1);
  localparam logic [3:0]  STROBE_INIT = 4'(STROBE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [11:0] r_addr;
  logic [7:0]  r_data;
  logic        r_n_we;
  logic        r_n_booted;
  logic        w_accept;
  logic        w_last;
  logic        w_n_we_nxt;
  logic        w_n_booted_nxt;

  assign IN_READY       = (r_state == S_LOAD) & N_RST;
  assign w_accept       = IN_READY & IN_VALID;
  assign w_last         = (r_addr == LAST_ADDR);
  assign BOOTSTRAP_ADDR = r_addr;
  assign BOOTSTRAP_DATA = r_data;
  assign BOOTSTRAP_N_WE = r_n_we;
  assign N_BOOTED       = r_n_booted;

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_accept) w_state_nxt = S_SETUP;
        else          w_state_nxt = S_LOAD;
      end
      S_SETUP:  w_state_nxt = S_STROBE;
      S_STROBE: begin
        if (r_cnt == 4'd0) w_state_nxt = S_HOLD;
        else               w_state_nxt = S_STROBE;
      end
      S_HOLD: begin
        if (w_last) w_state_nxt = S_DONE;
        else        w_state_nxt = S_LOAD;
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Strobe and boot flags are decoded from the next state and then registered.
  always_comb begin
    w_n_we_nxt     = 1'b1;
    w_n_booted_nxt = 1'b1;
    case (w_state_nxt)
      S_STROBE: begin
        w_n_we_nxt     = 1'b0;
        w_n_booted_nxt = 1'b1;
      end
      S_DONE: begin
        w_n_we_nxt     = 1'b1;
        w_n_booted_nxt = 1'b0;
      end
      default: begin
        w_n_we_nxt     = 1'b1;
        w_n_booted_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      r_cnt      <= 4'd0;
      r_addr     <= 12'd0;
      r_data     <= 8'd0;
      r_n_we     <= 1'b1;
      r_n_booted <= 1'b1;
    end else begin
      if (r_state == S_SETUP) begin
        r_cnt <= STROBE_INIT;
      end else if ((r_state == S_STROBE) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_cnt <= 4'd0;
      end
      if (w_accept) begin
        r_data <= IN_DATA;
      end
      // Address only advances on HOLD exit, so it is stable through the strobe.
      if ((r_state == S_HOLD) && !w_last) begin
        r_addr <= r_addr + 12'd1;
      end
      r_n_we     <= w_n_we_nxt;
      r_n_booted <= w_n_booted_nxt;
    end
  end

endmodule

// File: tb/tb_bootstrap_loader.sv
// Directed bench: five loader instances with different LENGTH/STROBE_CYCLES,
// an SRAM model fed from the write strobe, and protocol monitors.
module tb_bootstrap_loader;

  localparam int NI = 5;
  localparam int LENS[NI] = '{4, 16, 4, 4096, 1};
  localparam int STBS[NI] = '{1, 1, 3, 1, 1};

  logic        CLK;
  logic        rst  [NI];
  logic        vld  [NI];
  logic [7:0]  din  [NI];
  logic        rdy  [NI];
  logic [11:0] addr [NI];
  logic [7:0]  dat  [NI];
  logic        nwe  [NI];
  logic        nb   [NI];

  int n_chk  = 0;
  int n_fail = 0;
  int seed [NI];

  logic [7:0]  mem [NI][4096];
  int          falls [NI];
  int          run [NI];
  int          zero_falls [NI];
  int          boot_cyc [NI];
  int          fall_cyc [NI][16];
  logic [11:0] fall_addr [NI][16];
  logic [11:0] last_fall_addr [NI];
  logic        p_rst [NI];
  logic        p_nwe [NI];
  logic        p_nb [NI];
  logic [11:0] p_addr [NI];
  logic [7:0]  p_dat [NI];
  int inv_err = 0, stab_err = 0, run_err = 0, range_err = 0, cyc = 0;

  bootstrap_loader #(.LENGTH(4), .STROBE_CYCLES(1)) u_dut0 (
    .CLK(CLK), .N_RST(rst[0]), .IN_VALID(vld[0]), .IN_DATA(din[0]), .IN_READY(rdy[0]),
    .BOOTSTRAP_ADDR(addr[0]), .BOOTSTRAP_DATA(dat[0]), .BOOTSTRAP_N_WE(nwe[0]), .N_BOOTED(nb[0]));
  bootstrap_loader #(.LENGTH(16), .STROBE_CYCLES(1)) u_dut1 (
    .CLK(CLK), .N_RST(rst[1]), .IN_VALID(vld[1]), .IN_DATA(din[1]), .IN_READY(rdy[1]),
    .BOOTSTRAP_ADDR(addr[1]), .BOOTSTRAP_DATA(dat[1]), .BOOTSTRAP_N_WE(nwe[1]), .N_BOOTED(nb[1]));
  bootstrap_loader #(.LENGTH(4), .STROBE_CYCLES(3)) u_dut2 (
    .CLK(CLK), .N_RST(rst[2]), .IN_VALID(vld[2]), .IN_DATA(din[2]), .IN_READY(rdy[2]),
    .BOOTSTRAP_ADDR(addr[2]), .BOOTSTRAP_DATA(dat[2]), .BOOTSTRAP_N_WE(nwe[2]), .N_BOOTED(nb[2]));
  bootstrap_loader #(.LENGTH(4096), .STROBE_CYCLES(1)) u_dut3 (
    .CLK(CLK), .N_RST(rst[3]), .IN_VALID(vld[3]), .IN_DATA(din[3]), .IN_READY(rdy[3]),
    .BOOTSTRAP_ADDR(addr[3]), .BOOTSTRAP_DATA(dat[3]), .BOOTSTRAP_N_WE(nwe[3]), .N_BOOTED(nb[3]));
  bootstrap_loader #(.LENGTH(1), .STROBE_CYCLES(1)) u_dut4 (
    .CLK(CLK), .N_RST(rst[4]), .IN_VALID(vld[4]), .IN_DATA(din[4]), .IN_READY(rdy[4]),
    .BOOTSTRAP_ADDR(addr[4]), .BOOTSTRAP_DATA(dat[4]), .BOOTSTRAP_N_WE(nwe[4]), .N_BOOTED(nb[4]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i, input int k);
    logic [7:0] tbl [4];
    tbl = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    if (i == 0) return tbl[k % 4];
    return 8'((k * 29 + seed[i] * 71 + i * 13 + 7) % 256);
  endfunction

  // SRAM model and protocol monitors, sampled on the falling edge.
  initial begin
    for (int i = 0; i < NI; i++) begin
      falls[i] = 0; run[i] = 0; zero_falls[i] = 0; boot_cyc[i] = -1;
      p_rst[i] = 1'b0; p_nwe[i] = 1'b1; p_nb[i] = 1'b1;
      p_addr[i] = 12'd0; p_dat[i] = 8'd0; last_fall_addr[i] = 12'd0;
    end
    forever begin
      @(negedge CLK);
      cyc++;
      for (int i = 0; i < NI; i++) begin
        if (!nb[i] && !nwe[i]) inv_err++;
        if (int'(addr[i]) > LENS[i] - 1) range_err++;
        if (rst[i] && p_rst[i]) begin
          if (p_nwe[i] && !nwe[i]) begin
            if (falls[i] < 16) begin
              fall_addr[i][falls[i]] = addr[i];
              fall_cyc[i][falls[i]]  = cyc;
            end
            last_fall_addr[i] = addr[i];
            if (addr[i] == 12'd0) zero_falls[i]++;
            falls[i]++;
          end
          if (!p_nwe[i] && nwe[i] && run[i] != STBS[i]) run_err++;
          if ((!nwe[i] || !p_nwe[i]) && (addr[i] != p_addr[i] || dat[i] != p_dat[i])) stab_err++;
          if (p_nb[i] && !nb[i]) boot_cyc[i] = cyc;
        end
        if (!nwe[i]) mem[i][addr[i]] = dat[i];
        run[i]  = (rst[i] && !nwe[i]) ? run[i] + 1 : 0;
        p_rst[i] = rst[i]; p_nwe[i] = nwe[i]; p_nb[i] = nb[i];
        p_addr[i] = addr[i]; p_dat[i] = dat[i];
      end
    end
  end

  task automatic feed(input int i, input int n, input int maxgap);
    int gap;
    int t;
    for (int k = 0; k < n; k++) begin
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      if (gap > 0) begin
        vld[i] = 1'b0;
        repeat (gap) @(negedge CLK);
      end
      vld[i] = 1'b1;
      din[i] = pat(i, k);
      t = 0;
      while (!rdy[i] && t < 64) begin
        @(negedge CLK);
        t++;
      end
      if (t >= 64) begin
        check_val("accept_timeout", 32'd1, 32'd0);
        return;
      end
      @(negedge CLK);
    end
  endtask

  task automatic wait_booted(input int i);
    int t;
    t = 0;
    while (nb[i] && t < 100) begin
      @(negedge CLK);
      t++;
    end
    #1;
    check_val("n_booted_done", 32'(nb[i]), 32'd0);
    check_val("n_we_done", 32'(nwe[i]), 32'd1);
    check_val("ready_done", 32'(rdy[i]), 32'd0);
    check_val("addr_done", 32'(addr[i]), 32'(LENS[i] - 1));
  endtask

  task automatic post_done(input int i);
    int f;
    f = falls[i];
    vld[i] = 1'b1;
    repeat (20) @(negedge CLK);
    #1;
    check_val("no_write_in_done", 32'(falls[i]), 32'(f));
    check_val("addr_held_done", 32'(addr[i]), 32'(LENS[i] - 1));
    check_val("n_booted_held", 32'(nb[i]), 32'd0);
  endtask

  initial begin
    int errs;
    int f0;
    int t;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b0; vld[i] = 1'b0; din[i] = 8'h00; seed[i] = 0;
    end
    vld[0] = 1'b1;
    din[0] = 8'hFF;
    repeat (3) @(negedge CLK);
    #1;
    check_val("rst_ready", 32'(rdy[0]), 32'd0);
    check_val("rst_addr", 32'(addr[0]), 32'd0);
    check_val("rst_data", 32'(dat[0]), 32'd0);
    check_val("rst_n_we", 32'(nwe[0]), 32'd1);
    check_val("rst_n_booted", 32'(nb[0]), 32'd1);
    vld[0] = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < NI; i++) rst[i] = 1'b1;
    #1;
    check_val("ready_after_rst", 32'(rdy[0]), 32'd1);
    @(negedge CLK);

    // LENGTH=4, valid held high: one write every 4 cycles.
    feed(0, 4, 0);
    wait_booted(0);
    check_val("t1_falls", 32'(falls[0]), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check_val("t1_addr", 32'(fall_addr[0][k]), 32'(k));
      check_val("t1_mem", 32'(mem[0][k]), 32'(pat(0, k)));
      if (k > 0) check_val("t1_spacing", 32'(fall_cyc[0][k] - fall_cyc[0][k-1]), 32'd4);
    end
    check_val("t1_boot_lat", 32'(boot_cyc[0] - fall_cyc[0][3]), 32'd2);
    post_done(0);

    // LENGTH=16 with random source gaps.
    feed(1, 16, 5);
    wait_booted(1);
    check_val("t2_falls", 32'(falls[1]), 32'd16);
    for (int k = 0; k < 16; k++) check_val("t2_mem", 32'(mem[1][k]), 32'(pat(1, k)));

    // STROBE_CYCLES=3.
    feed(2, 4, 2);
    wait_booted(2);
    check_val("t3_falls", 32'(falls[2]), 32'd4);
    for (int k = 0; k < 4; k++) check_val("t3_mem", 32'(mem[2][k]), 32'(pat(2, k)));
    check_val("t3_boot_lat", 32'(boot_cyc[2] - fall_cyc[2][3]), 32'd4);

    // Reset during the strobe of the second byte, then full reload.
    @(negedge CLK);
    rst[2] = 1'b0;
    repeat (2) @(negedge CLK);
    rst[2] = 1'b1;
    seed[2] = 1;
    feed(2, 1, 0);
    din[2] = pat(2, 1);
    t = 0;
    while (!(nwe[2] == 1'b0 && addr[2] == 12'd1) && t < 64) begin
      @(negedge CLK);
      t++;
    end
    check_val("t4_reach_strobe", 32'(t < 64), 32'd1);
    #2;
    rst[2] = 1'b0;
    #1;
    check_val("t4_n_we_async", 32'(nwe[2]), 32'd1);
    check_val("t4_addr_rst", 32'(addr[2]), 32'd0);
    check_val("t4_n_booted_rst", 32'(nb[2]), 32'd1);
    vld[2] = 1'b0;
    repeat (2) @(negedge CLK);
    rst[2] = 1'b1;
    seed[2] = 2;
    f0 = falls[2];
    #1;
    check_val("t4_ready_release", 32'(rdy[2]), 32'd1);
    check_val("t4_n_booted_release", 32'(nb[2]), 32'd1);
    @(negedge CLK);
    feed(2, 4, 0);
    wait_booted(2);
    check_val("t4_reload_falls", 32'(falls[2] - f0), 32'd4);
    check_val("t4_first_addr", 32'(fall_addr[2][f0]), 32'd0);
    for (int k = 0; k < 4; k++) check_val("t4_mem", 32'(mem[2][k]), 32'(pat(2, k)));

    // LENGTH=4096: last write at 0xFFF, no wrap.
    feed(3, 4096, 0);
    wait_booted(3);
    check_val("t5_falls", 32'(falls[3]), 32'd4096);
    check_val("t5_last_addr", 32'(last_fall_addr[3]), 32'h0000_0FFF);
    check_val("t5_zero_writes", 32'(zero_falls[3]), 32'd1);
    errs = 0;
    for (int k = 0; k < 4096; k++) if (mem[3][k] !== pat(3, k)) errs++;
    check_val("t5_mem", 32'(errs), 32'd0);
    post_done(3);

    // LENGTH=1.
    feed(4, 1, 0);
    wait_booted(4);
    check_val("t6_falls", 32'(falls[4]), 32'd1);
    check_val("t6_addr", 32'(fall_addr[4][0]), 32'd0);
    check_val("t6_mem", 32'(mem[4][0]), 32'(pat(4, 0)));
    check_val("t6_boot_lat", 32'(boot_cyc[4] - fall_cyc[4][0]), 32'd2);
    post_done(4);

    check_val("inv_nbooted_or_nwe", 32'(inv_err), 32'd0);
    check_val("addr_data_stable", 32'(stab_err), 32'd0);
    check_val("strobe_width", 32'(run_err), 32'd0);
    check_val("addr_range", 32'(range_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
